// File: rtl/idu_pkg.sv
// Shared IDU definitions: immediate format codes (common to the decoder
// and the encoder), immediate field masks in instruction coordinates,
// and a helper that checks whether a value fits a signed field.
package idu_pkg;

    // ext_opt format codes; 3'b101..3'b111 are illegal
    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    // Instruction bits owned by each immediate format
    localparam logic [31:0] MASK_I  = 32'hFFF0_0000;  // [31:20]
    localparam logic [31:0] MASK_U  = 32'hFFFF_F000;  // [31:12]
    localparam logic [31:0] MASK_SB = 32'hFE00_0F80;  // [31:25], [11:7]
    localparam logic [31:0] MASK_J  = 32'hFFFF_F000;  // [31:12]

    // Field bit positions
    localparam int POS_OPC_MSB = 6;
    localparam int POS_RD_LSB  = 7;
    localparam int POS_RS1_LSB = 15;
    localparam int POS_RS2_LSB = 20;
    localparam int POS_F7_LSB  = 25;

    // True when v[31:lsb] are all equal, i.e. v is a sign extension of
    // its low lsb+1 bits.
    function automatic logic upper_all_equal(input logic [31:0] v,
                                             input logic [4:0]  lsb);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << lsb;
        return ((v & m) == m) || ((v & m) == 32'h0);
    endfunction

endpackage

// File: rtl/imm_scatter.sv
// Combinational immediate scatter: clears the immediate bits of inst for
// the selected format and fills them from imm.
// Ports:
//   inst     in  32  base instruction
//   ext_opt  in  3   format code (I/U/S/B/J, others illegal)
//   imm      in  32  immediate value (byte offset for B/J)
//   inst_out out 32  instruction with immediate fields written
//   err      out 1   value does not fit / misaligned / illegal format
module imm_scatter
    import idu_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [2:0]  ext_opt,
    input  logic [31:0] imm,
    output logic [31:0] inst_out,
    output logic        err
);

    logic [31:0] mask;
    logic [31:0] field;

    always_comb begin
        mask  = 32'h0;
        field = 32'h0;
        err   = 1'b1;
        case (ext_opt)
            EXT_I: begin
                mask  = MASK_I;
                field = {imm[11:0], 20'h0};
                err   = !upper_all_equal(imm, 5'd11);
            end
            EXT_U: begin
                mask  = MASK_U;
                field = {imm[31:12], 12'h0};
                err   = |imm[11:0];
            end
            EXT_S: begin
                mask  = MASK_SB;
                field = {imm[11:5], 13'h0, imm[4:0], 7'h0};
                err   = !upper_all_equal(imm, 5'd11);
            end
            EXT_B: begin
                mask  = MASK_SB;
                field = {imm[12], imm[10:5], 13'h0, imm[4:1], imm[11], 7'h0};
                err   = imm[0] || !upper_all_equal(imm, 5'd12);
            end
            EXT_J: begin
                mask  = MASK_J;
                field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h0};
                err   = imm[0] || !upper_all_equal(imm, 5'd20);
            end
            default: begin
                // illegal format: mask stays empty so inst passes through
                mask  = 32'h0;
                field = 32'h0;
                err   = 1'b1;
            end
        endcase
    end

    // Out-of-range values are still written truncated; err is advisory.
    assign inst_out = (inst & ~mask) | field;

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: two-stage valid/ready pipeline around imm_scatter,
// with sticky error flag and saturating encode/error counters.
// Ports:
//   clock, reset        clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_inst/in_ext_opt/in_imm  request payload
//   out_valid/out_ready result handshake
//   out_inst/out_err    encoded instruction and error flag
//   err_sticky          set by any errored output handshake
//   clr                 clears err_sticky and both counters
//   enc_cnt/err_cnt     saturating handshake / errored-handshake counts
module imm_encoder
    import idu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_ext_opt,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic             err_sticky,
    input  logic             clr,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic        s0_valid_reg;
    logic [31:0] s0_inst_reg;
    logic [2:0]  s0_ext_reg;
    logic [31:0] s0_imm_reg;

    logic        s1_valid_reg;
    logic [31:0] s1_inst_reg;
    logic        s1_err_reg;

    logic        s0_adv;
    logic        in_hs;
    logic        out_hs;
    logic [31:0] enc_inst;
    logic        enc_err;

    // Stage 1 can take new data when empty or draining this cycle.
    assign s0_adv   = !s1_valid_reg || out_ready;
    assign in_ready = !s0_valid_reg || s0_adv;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = s1_valid_reg && out_ready;

    imm_scatter u_scatter (
        .inst     (s0_inst_reg),
        .ext_opt  (s0_ext_reg),
        .imm      (s0_imm_reg),
        .inst_out (enc_inst),
        .err      (enc_err)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s0_valid_reg <= 1'b0;
            s0_inst_reg  <= 32'h0;
            s0_ext_reg   <= 3'b000;
            s0_imm_reg   <= 32'h0;
        end else if (in_hs) begin
            s0_valid_reg <= 1'b1;
            s0_inst_reg  <= in_inst;
            s0_ext_reg   <= in_ext_opt;
            s0_imm_reg   <= in_imm;
        end else if (s0_adv) begin
            s0_valid_reg <= 1'b0;
        end
    end

    // s1 follows s0 whenever it advances; an empty s0 drains s1.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_inst_reg  <= 32'h0;
            s1_err_reg   <= 1'b0;
        end else if (s0_adv) begin
            s1_valid_reg <= s0_valid_reg;
            if (s0_valid_reg) begin
                s1_inst_reg <= enc_inst;
                s1_err_reg  <= enc_err;
            end
        end
    end

    assign out_valid = s1_valid_reg;
    assign out_inst  = s1_inst_reg;
    assign out_err   = s1_err_reg;

    // Counter 0 counts all output handshakes, counter 1 errored ones.
    logic             cnt_inc [2];
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_inc[0] = out_hs;
    assign cnt_inc[1] = out_hs && s1_err_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_ff @(posedge clock) begin
            if (reset || clr) begin
                cnt_reg[gi] <= '0;
            end else if (cnt_inc[gi] && !(&cnt_reg[gi])) begin
                cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    end

    assign enc_cnt = cnt_reg[0];
    assign err_cnt = cnt_reg[1];

    logic err_sticky_reg;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            err_sticky_reg <= 1'b0;
        end else if (out_hs && s1_err_reg) begin
            err_sticky_reg <= 1'b1;
        end
    end

    assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;
    import idu_pkg::*;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [2:0]  in_ext_opt;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic        err_sticky;
    logic        clr;
    logic [15:0] enc_cnt;
    logic [15:0] err_cnt;

    // second instance with narrow counters, same stimulus
    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_out_inst;
    logic        sat_out_err;
    logic        sat_err_sticky;
    logic [1:0]  sat_enc_cnt;
    logic [1:0]  sat_err_cnt;

    int compared   = 0;
    int mismatched = 0;

    imm_encoder #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_ext_opt(in_ext_opt), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err),
        .err_sticky(err_sticky), .clr(clr),
        .enc_cnt(enc_cnt), .err_cnt(err_cnt)
    );

    imm_encoder #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_inst(in_inst), .in_ext_opt(in_ext_opt), .in_imm(in_imm),
        .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_inst(sat_out_inst), .out_err(sat_out_err),
        .err_sticky(sat_err_sticky), .clr(clr),
        .enc_cnt(sat_enc_cnt), .err_cnt(sat_err_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request with out_ready high; checks 2-cycle latency and result.
    // Returns with the result presented (handshake on the next edge).
    task automatic send_one(input string tag, input logic [31:0] inst,
                            input logic [2:0] ext, input logic [31:0] imm,
                            input logic [31:0] exp_inst, input logic exp_err);
        int n;
        in_inst    = inst;
        in_ext_opt = ext;
        in_imm     = imm;
        in_valid   = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clock); #1;
        check({tag, "_lat2"}, 32'(out_valid), 32'd1);
        check({tag, "_inst"}, out_inst, exp_inst);
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        $display("txn %s ext=%b imm=%h -> inst=%h err=%b", tag, ext, imm,
                 out_inst, out_err);
    endtask

    int          idx;
    int          got;
    logic        rdy;

    initial begin
        reset      = 1'b1;
        clr        = 1'b0;
        in_valid   = 1'b0;
        in_inst    = 32'h0;
        in_ext_opt = 3'b000;
        in_imm     = 32'h0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        check("rst_enc_cnt", 32'(enc_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);

        // format vectors
        send_one("i_neg1",  32'h0000_0093, EXT_I, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        send_one("u_ok",    32'h0000_00B7, EXT_U, 32'h1234_5000, 32'h1234_50B7, 1'b0);
        send_one("u_bad",   32'h0000_00B7, EXT_U, 32'h1234_5001, 32'h1234_50B7, 1'b1);
        @(posedge clock); #1;
        check("sticky_set", 32'(err_sticky), 32'd1);
        check("err_cnt_1", 32'(err_cnt), 32'd1);
        check("enc_cnt_3", 32'(enc_cnt), 32'd3);

        send_one("b_pos",   32'h0000_0063, EXT_B, 32'h0000_0010, 32'h0000_0863, 1'b0);
        send_one("j_800",   32'h0000_00EF, EXT_J, 32'h0000_0800, 32'h0010_00EF, 1'b0);
        send_one("s_range", 32'h0000_0023, EXT_S, 32'h0000_0800, 32'h8000_0023, 1'b1);
        send_one("illegal", 32'h1234_5678, 3'b111, 32'h0000_0004, 32'h1234_5678, 1'b1);
        send_one("b_neg2",  32'h0000_0063, EXT_B, 32'hFFFF_FFFE, 32'hFE00_0FE3, 1'b0);
        send_one("b_odd",   32'h0000_0063, EXT_B, 32'h0000_0011, 32'h0000_0863, 1'b1);
        send_one("j_neg2",  32'h0000_00EF, EXT_J, 32'hFFFF_FFFE, 32'hFFFF_F0EF, 1'b0);
        send_one("j_range", 32'h0000_00EF, EXT_J, 32'h0010_0000, 32'h8000_00EF, 1'b1);
        send_one("i_clear", 32'hFFF0_0093, EXT_I, 32'h0000_0000, 32'h0000_0093, 1'b0);
        send_one("s_neg",   32'h0000_0023, EXT_S, 32'hFFFF_FFFF, 32'hFE00_0FA3, 1'b0);
        @(posedge clock); #1;
        check("enc_cnt_13", 32'(enc_cnt), 32'd13);
        check("err_cnt_5", 32'(err_cnt), 32'd5);
        check("sat_enc_3", 32'(sat_enc_cnt), 32'd3);

        // plain clr
        clr = 1'b1;
        @(posedge clock); #1;
        clr = 1'b0;
        check("clr_enc", 32'(enc_cnt), 32'd0);
        check("clr_err", 32'(err_cnt), 32'd0);
        check("clr_sticky", 32'(err_sticky), 32'd0);

        // backpressure: 5 cycles with out_ready low
        out_ready  = 1'b0;
        idx        = 0;
        got        = 0;
        in_inst    = 32'h0000_0013;
        in_ext_opt = EXT_I;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            in_imm   = 32'(idx + 1);
            #1;
            rdy = in_ready;
            @(posedge clock); #1;
            if (in_valid && rdy) idx++;
            if (c >= 1) check("bp_hold", out_inst, 32'h0010_0013);
        end
        check("bp_accepts", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            in_valid = (idx < 4);
            in_imm   = 32'(idx + 1);
            #1;
            rdy = in_ready;
            if (out_valid) begin
                check("bp_order", out_inst, 32'h13 | (32'(got + 1) << 20));
                $display("txn bp_%0d inst=%h err=%b", got, out_inst, out_err);
                got++;
            end
            @(posedge clock); #1;
            if (in_valid && rdy) idx++;
        end
        in_valid = 1'b0;
        check("bp_delivered", 32'(got), 32'd4);
        check("bp_enc_cnt", 32'(enc_cnt), 32'd4);
        check("bp_err_cnt", 32'(err_cnt), 32'd0);

        // reset with both stages full
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_imm     = 32'h0000_0007;
        @(posedge clock); #1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_enc", 32'(enc_cnt), 32'd0);
        check("mid_rst_out_inst", out_inst, 32'h0);
        @(posedge clock); #1;
        check("mid_rst_no_ghost", 32'(out_valid), 32'd0);

        // saturation of the narrow counter
        for (int k = 0; k < 5; k++) begin
            send_one("sat", 32'h0000_0013, EXT_I, 32'(k), 32'h13 | (32'(k) << 20), 1'b0);
        end
        @(posedge clock); #1;
        check("sat_main_enc_5", 32'(enc_cnt), 32'd5);
        check("sat_narrow_enc_3", 32'(sat_enc_cnt), 32'd3);

        // clr in the same cycle as an errored handshake
        send_one("clr_hs", 32'h1234_5678, 3'b101, 32'h0, 32'h1234_5678, 1'b1);
        clr = 1'b1;
        @(posedge clock); #1;
        clr = 1'b0;
        check("clr_hs_sticky", 32'(err_sticky), 32'd0);
        check("clr_hs_err_cnt", 32'(err_cnt), 32'd0);
        check("clr_hs_enc_cnt", 32'(enc_cnt), 32'd0);
        check("clr_hs_drained", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
